reorder_buffer: RTL and testbench

Circular reorder buffer between the decoder/issue stage and the register file. Allocates one entry per decoded instruction, tracks completion from two writeback buses, and retires one instruction per cycle in program order. Retirement drives the register-file commit port (`rob_rf_*`), releases stores to the load/store buffer, and raises a pipeline-wide flush on a mispredicted branch. Also answers operand-value queries from the issue stage.

---
 rtl/reorder_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries at tail from the decoder, collects
// results from the ALU and LSB writeback buses, and retires one entry per cycle
// in program order onto the register-file commit port, the store-release strobe
// or the mispredict flush.
//
// Optional feature macro: ROB_CDB_BYPASS_EN
//   defined   -> operand queries also see same-cycle writeback bus results
//   undefined -> operand queries see registered entry state only
//
// Opcode class encoding on dec_op (INST_OP_WIDTH bits):
//   0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BEQ, 5 BNE, 6 BLT, 7 BGE, 8 BLTU, 9 BGEU,
//   10..14 loads, 15 SB, 16 SH, 17 SW, 18 and above register-writing ALU ops.
module reorder_buffer #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int XLEN           = 32,
    parameter int INST_OP_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      stall,
    input  logic                      dec_ready,
    input  logic [INST_OP_WIDTH-1:0]  dec_op,
    input  logic [4:0]                dec_rd,
    input  logic [XLEN-1:0]           dec_pc,
    input  logic                      dec_pred_jump,
    input  logic                      alu_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
    input  logic [XLEN-1:0]           alu_val,
    input  logic                      alu_jump,
    input  logic [XLEN-1:0]           alu_target,
    input  logic                      lsb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
    input  logic [XLEN-1:0]           lsb_val,
    input  logic [ROB_SIZE_WIDTH-1:0] qry_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] qry_id2,
    output logic                      qry_ready1,
    output logic                      qry_ready2,
    output logic [XLEN-1:0]           qry_val1,
    output logic [XLEN-1:0]           qry_val2,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
    output logic                      rob_rf_enable,
    output logic [4:0]                rob_rf_rd,
    output logic [XLEN-1:0]           rob_rf_val,
    output logic                      rob_store_commit,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc
);
    localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
    localparam int CNT_W    = ROB_SIZE_WIDTH + 1;

    localparam logic [INST_OP_WIDTH-1:0] OP_BEQ  = INST_OP_WIDTH'(4);
    localparam logic [INST_OP_WIDTH-1:0] OP_BNE  = INST_OP_WIDTH'(5);
    localparam logic [INST_OP_WIDTH-1:0] OP_BLT  = INST_OP_WIDTH'(6);
    localparam logic [INST_OP_WIDTH-1:0] OP_BGE  = INST_OP_WIDTH'(7);
    localparam logic [INST_OP_WIDTH-1:0] OP_BLTU = INST_OP_WIDTH'(8);
    localparam logic [INST_OP_WIDTH-1:0] OP_BGEU = INST_OP_WIDTH'(9);
    localparam logic [INST_OP_WIDTH-1:0] OP_SB   = INST_OP_WIDTH'(15);
    localparam logic [INST_OP_WIDTH-1:0] OP_SH   = INST_OP_WIDTH'(16);
    localparam logic [INST_OP_WIDTH-1:0] OP_SW   = INST_OP_WIDTH'(17);

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2
    } kind_e;

    // Entry storage
    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] pred_q;
    logic [ROB_SIZE-1:0] act_q;
    kind_e               kind_q   [ROB_SIZE];
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [XLEN-1:0]     val_q    [ROB_SIZE];
    logic [XLEN-1:0]     pc_q     [ROB_SIZE];
    logic [XLEN-1:0]     target_q [ROB_SIZE];

    logic [ROB_SIZE_WIDTH-1:0] head_q;
    logic [ROB_SIZE_WIDTH-1:0] tail_q;
    logic [CNT_W-1:0]          count_q;

    // Registered commit-side outputs
    logic            rf_en_q;
    logic [4:0]      rf_rd_q;
    logic [XLEN-1:0] rf_val_q;
    logic            store_q;
    logic            flush_q;
    logic [XLEN-1:0] flush_pc_q;

    kind_e dec_kind;
    logic  full;
    logic  alloc;
    logic  retire;
    logic  mispredict;

    // Classify the incoming instruction; jumps resolve in the front end so they are plain REG
    always_comb begin
        dec_kind = KIND_REG;
        case (dec_op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: dec_kind = KIND_BRANCH;
            OP_SB, OP_SH, OP_SW:                              dec_kind = KIND_STORE;
            default:                                          dec_kind = KIND_REG;
        endcase
    end

    // Allocation / retirement decisions from registered state
    always_comb begin
        full       = (count_q == CNT_W'(ROB_SIZE));
        alloc      = dec_ready && !stall && !full;
        retire     = busy_q[head_q] && ready_q[head_q];
        mispredict = retire && (kind_q[head_q] == KIND_BRANCH)
                     && (act_q[head_q] != pred_q[head_q]);
    end

    // Entry, pointer and commit-output state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q     <= '0;
            ready_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_en_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_val_q   <= '0;
            store_q    <= 1'b0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (!rdy) begin
            rf_en_q <= 1'b0;
            store_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            rf_en_q <= 1'b0;
            store_q <= 1'b0;
            flush_q <= 1'b0;
            if (retire) begin
                case (kind_q[head_q])
                    KIND_REG: begin
                        rf_en_q  <= 1'b1;
                        rf_rd_q  <= rd_q[head_q];
                        rf_val_q <= val_q[head_q];
                    end
                    KIND_STORE: store_q <= 1'b1;
                    default: begin
                        if (mispredict) begin
                            flush_q    <= 1'b1;
                            flush_pc_q <= act_q[head_q] ? target_q[head_q]
                                                        : pc_q[head_q] + XLEN'(4);
                        end
                    end
                endcase
            end

            if (mispredict) begin
                // Everything younger than the branch is wrong-path work
                busy_q  <= '0;
                ready_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (retire) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + 1'b1;
                end
                if (alloc) begin
                    busy_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]  <= 1'b0;
                    kind_q[tail_q]   <= dec_kind;
                    rd_q[tail_q]     <= dec_rd;
                    pc_q[tail_q]     <= dec_pc;
                    pred_q[tail_q]   <= dec_pred_jump;
                    tail_q           <= tail_q + 1'b1;
                end
                if (alu_valid) begin
                    ready_q[alu_id]  <= 1'b1;
                    val_q[alu_id]    <= alu_val;
                    act_q[alu_id]    <= alu_jump;
                    target_q[alu_id] <= alu_target;
                end
                // Placed after the ALU write so LSB wins on an id collision
                if (lsb_valid) begin
                    ready_q[lsb_id]  <= 1'b1;
                    val_q[lsb_id]    <= lsb_val;
                end
                count_q <= count_q + CNT_W'(alloc) - CNT_W'(retire);
            end
        end
    end

    // Operand lookups for the issue stage
    always_comb begin
        qry_ready1 = busy_q[qry_id1] && ready_q[qry_id1];
        qry_val1   = val_q[qry_id1];
        qry_ready2 = busy_q[qry_id2] && ready_q[qry_id2];
        qry_val2   = val_q[qry_id2];
`ifdef ROB_CDB_BYPASS_EN
        if (lsb_valid && lsb_id == qry_id1) begin
            qry_ready1 = 1'b1;
            qry_val1   = lsb_val;
        end else if (alu_valid && alu_id == qry_id1) begin
            qry_ready1 = 1'b1;
            qry_val1   = alu_val;
        end
        if (lsb_valid && lsb_id == qry_id2) begin
            qry_ready2 = 1'b1;
            qry_val2   = lsb_val;
        end else if (alu_valid && alu_id == qry_id2) begin
            qry_ready2 = 1'b1;
            qry_val2   = alu_val;
        end
`endif
    end

    assign rob_full         = full;
    assign rob_head_id      = head_q;
    assign rob_tail_id      = tail_q;
    assign rob_rf_enable    = rf_en_q & rdy;
    assign rob_rf_rd        = rf_rd_q;
    assign rob_rf_val       = rf_val_q;
    assign rob_store_commit = store_q & rdy;
    assign flush            = flush_q & rdy;
    assign flush_pc         = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table of inputs and
// expected commit-side outputs, followed by hand-written query and reset cases.
module tb_reorder_buffer;
    localparam int OP_ADDI = 19;
    localparam int OP_ADD  = 20;
    localparam int OP_BEQ  = 4;
    localparam int OP_BNE  = 5;
    localparam int OP_BLT  = 6;
    localparam int OP_SB   = 15;
    localparam int OP_SW   = 17;

`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        stall = 1'b0;
    logic        dec_ready = 1'b0;
    logic [5:0]  dec_op = '0;
    logic [4:0]  dec_rd = '0;
    logic [31:0] dec_pc = '0;
    logic        dec_pred_jump = 1'b0;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_id = '0;
    logic [31:0] alu_val = '0;
    logic        alu_jump = 1'b0;
    logic [31:0] alu_target = '0;
    logic        lsb_valid = 1'b0;
    logic [2:0]  lsb_id = '0;
    logic [31:0] lsb_val = '0;
    logic [2:0]  qry_id1 = '0;
    logic [2:0]  qry_id2 = '0;
    logic        qry_ready1, qry_ready2;
    logic [31:0] qry_val1, qry_val2;
    logic        rob_full;
    logic [2:0]  rob_head_id, rob_tail_id;
    logic        rob_rf_enable;
    logic [4:0]  rob_rf_rd;
    logic [31:0] rob_rf_val;
    logic        rob_store_commit;
    logic        flush;
    logic [31:0] flush_pc;

    int n_checks = 0;
    int n_errors = 0;

    reorder_buffer #(.ROB_SIZE_WIDTH(3), .XLEN(32), .INST_OP_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall(stall),
        .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd), .dec_pc(dec_pc),
        .dec_pred_jump(dec_pred_jump),
        .alu_valid(alu_valid), .alu_id(alu_id), .alu_val(alu_val),
        .alu_jump(alu_jump), .alu_target(alu_target),
        .lsb_valid(lsb_valid), .lsb_id(lsb_id), .lsb_val(lsb_val),
        .qry_id1(qry_id1), .qry_id2(qry_id2),
        .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
        .qry_val1(qry_val1), .qry_val2(qry_val2),
        .rob_full(rob_full), .rob_head_id(rob_head_id), .rob_tail_id(rob_tail_id),
        .rob_rf_enable(rob_rf_enable), .rob_rf_rd(rob_rf_rd), .rob_rf_val(rob_rf_val),
        .rob_store_commit(rob_store_commit), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one rising edge, then outputs expected just after it.
    // rf rd/val are compared only when rf is expected, flush_pc only when flush is expected.
    typedef struct {
        int          rst, rdy, stall, dec, op, rd;
        logic [31:0] pc;
        int          pred, av, aid;
        logic [31:0] aval;
        int          aj;
        logic [31:0] at;
        int          lv, lid;
        logic [31:0] lval;
        int          erf, erd;
        logic [31:0] eval;
        int          est, efl;
        logic [31:0] efpc;
        int          eh, et, ef;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input vec_t v);
        rst_n         = (v.rst == 0);
        rdy           = (v.rdy != 0);
        stall         = (v.stall != 0);
        dec_ready     = (v.dec != 0);
        dec_op        = 6'(v.op);
        dec_rd        = 5'(v.rd);
        dec_pc        = v.pc;
        dec_pred_jump = (v.pred != 0);
        alu_valid     = (v.av != 0);
        alu_id        = 3'(v.aid);
        alu_val       = v.aval;
        alu_jump      = (v.aj != 0);
        alu_target    = v.at;
        lsb_valid     = (v.lv != 0);
        lsb_id        = 3'(v.lid);
        lsb_val       = v.lval;
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_row(input int idx, input vec_t v);
        logic ok;
        ok = (rob_rf_enable === (v.erf != 0))
          && (rob_store_commit === (v.est != 0))
          && (flush === (v.efl != 0))
          && (int'(rob_head_id) == v.eh)
          && (int'(rob_tail_id) == v.et)
          && (rob_full === (v.ef != 0));
        if (v.erf != 0) ok = ok && (int'(rob_rf_rd) == v.erd) && (rob_rf_val === v.eval);
        if (v.efl != 0) ok = ok && (flush_pc === v.efpc);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL row%0d: got rf=%0b rd=%0d val=0x%0h st=%0b fl=%0b fpc=0x%0h h=%0d t=%0d full=%0b expected rf=%0d rd=%0d val=0x%0h st=%0d fl=%0d fpc=0x%0h h=%0d t=%0d full=%0d",
                     idx, rob_rf_enable, rob_rf_rd, rob_rf_val, rob_store_commit, flush, flush_pc,
                     rob_head_id, rob_tail_id, rob_full,
                     v.erf, v.erd, v.eval, v.est, v.efl, v.efpc, v.eh, v.et, v.ef);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst rdy stall dec op rd pc pred | av aid aval aj at | lv lid lval | erf erd eval est efl efpc | eh et ef
        vecs.push_back('{1,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0});
        // Fill all eight entries with REG instructions, no writeback
        for (int i = 0; i < 8; i++)
            vecs.push_back('{0,1,0,1,OP_ADD,i+1,i*4,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,(i+1)%8,(i==7)});
        vecs.push_back('{0,1,1,1,OP_ADD,9,32'h20,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,1});
        // Out-of-order writeback 2,1,0 then in-order commits
        vecs.push_back('{0,1,1,0,0,0,0,0, 1,2,32'h22,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,1});
        vecs.push_back('{0,1,1,0,0,0,0,0, 1,1,32'h11,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,1});
        vecs.push_back('{0,1,1,0,0,0,0,0, 0,0,0,0,0, 1,0,32'h10, 0,0,0,0,0,0, 0,0,1});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,1,32'h10,0,0,0, 1,0,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,2,32'h11,0,0,0, 2,0,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,3,32'h22,0,0,0, 3,0,0});
        // Both buses hit id 3 together: LSB value wins
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,3,32'hAA,0,0, 1,3,32'hBB, 0,0,0,0,0,0, 3,0,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,4,32'hBB,0,0,0, 4,0,0});
        // Entry 4 becomes ready, but reset lands on the edge it would commit
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,4,32'h44,0,0, 0,0,0, 0,0,0,0,0,0, 4,0,0});
        vecs.push_back('{1,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0});
        // Minimum-latency commit
        vecs.push_back('{0,1,0,1,OP_ADD,5,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,0,32'h1234,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,5,32'h1234,0,0,0, 1,1,0});
        vecs.push_back('{1,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0});
        // Mispredicted not-taken branch at 0x100, actually taken to 0x200
        vecs.push_back('{0,1,0,1,OP_BEQ,0,32'h100,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0});
        vecs.push_back('{0,1,0,1,OP_ADD,7,32'h104,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,2,0});
        vecs.push_back('{0,1,0,1,OP_SW,0,32'h108,0, 1,1,32'h77,0,0, 1,2,0, 0,0,0,0,0,0, 0,3,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,0,0,1,32'h200, 0,0,0, 0,0,0,0,0,0, 0,3,0});
        vecs.push_back('{0,1,0,1,OP_ADD,9,32'h10C,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,1,32'h200, 0,0,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0});
        // Correct taken prediction, store release, then mispredicted taken -> pc+4
        vecs.push_back('{0,1,0,1,OP_BNE,0,32'h300,1, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0});
        vecs.push_back('{0,1,0,1,OP_SB,0,32'h304,0, 1,0,0,1,32'h400, 0,0,0, 0,0,0,0,0,0, 0,2,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 1,1,0, 0,0,0,0,0,0, 1,2,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,1,0,0, 2,2,0});
        vecs.push_back('{0,1,0,1,OP_BLT,0,32'h308,1, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 2,3,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,2,0,0,0, 0,0,0, 0,0,0,0,0,0, 2,3,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,1,32'h30C, 0,0,0});
        // rd=0 still pulses the commit port
        vecs.push_back('{0,1,0,1,OP_ADDI,0,32'h310,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,0,5,0,0, 0,0,0, 0,0,0,0,0,0, 0,1,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,0,5,0,0,0, 1,1,0});
        // rdy low freezes allocation, writeback and retirement
        vecs.push_back('{0,0,0,1,OP_ADD,3,32'h314,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,1,0});
        vecs.push_back('{0,1,0,1,OP_ADD,3,32'h314,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,2,0});
        vecs.push_back('{0,0,0,0,0,0,0,0, 1,1,32'h55,0,0, 0,0,0, 0,0,0,0,0,0, 1,2,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,2,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 1,1,32'h66,0,0, 0,0,0, 0,0,0,0,0,0, 1,2,0});
        vecs.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 1,2,0});
        vecs.push_back('{0,1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,3,32'h66,0,0,0, 2,2,0});

        #2;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            check_row(i, vecs[i]);
        end

        // Query: result on the LSB bus for id 3 while it is pending
        rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; dec_ready = 1'b0;
        alu_valid = 1'b0; lsb_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dec_ready = 1'b1; dec_op = 6'(OP_ADD); dec_rd = 5'(10 + i); dec_pc = 32'(i * 4);
            tick();
        end
        dec_ready = 1'b0;
        check_word("tail_after_4", 32'(rob_tail_id), 32'd4);
        lsb_valid = 1'b1; lsb_id = 3'd3; lsb_val = 32'hABCD;
        qry_id1 = 3'd3; qry_id2 = 3'd0;
        #1;
        check_bit("qry1_ready_same_cycle", qry_ready1, BYP);
        if (BYP) check_word("qry1_val_same_cycle", qry_val1, 32'hABCD);
        check_bit("qry2_ready_pending", qry_ready2, 1'b0);
        tick();
        lsb_valid = 1'b0;
        qry_id2 = 3'd3;
        #1;
        check_bit("qry1_ready_next_cycle", qry_ready1, 1'b1);
        check_word("qry1_val_next_cycle", qry_val1, 32'hABCD);
        check_bit("qry2_ready_next_cycle", qry_ready2, 1'b1);
        check_word("qry2_val_next_cycle", qry_val2, 32'hABCD);

        // Reset with four entries pending and the head about to become ready
        alu_valid = 1'b1; alu_id = 3'd0; alu_val = 32'h99;
        tick();
        alu_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check_bit("rst_rf_enable", rob_rf_enable, 1'b0);
        check_bit("rst_store", rob_store_commit, 1'b0);
        check_bit("rst_flush", flush, 1'b0);
        check_word("rst_rf_rd", 32'(rob_rf_rd), 32'd0);
        check_word("rst_rf_val", rob_rf_val, 32'd0);
        check_word("rst_flush_pc", flush_pc, 32'd0);
        check_word("rst_head", 32'(rob_head_id), 32'd0);
        check_word("rst_tail", 32'(rob_tail_id), 32'd0);
        check_bit("rst_full", rob_full, 1'b0);
        check_bit("rst_qry_cleared", qry_ready1, 1'b0);
        rst_n = 1'b1;
        tick();
        check_bit("post_rst_no_commit", rob_rf_enable, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
